// File: rtl/ariane_pkg.sv
// Shared constants and types for the vpack requantize-and-pack engine.
// Widths: int32 accumulator in, four int8 lanes out, 5-bit shift amount.
package ariane_pkg;

  localparam int VPACK_ACC_W    = 32;
  localparam int VPACK_SHIFT_W  = 5;
  localparam int VPACK_ELEM_W   = 8;
  localparam int VPACK_LANES    = 4;
  localparam int VPACK_ELEM_MAX = 127;
  localparam int VPACK_ELEM_MIN = -128;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } vpack_state_e;

endpackage

// File: rtl/vpack_requant_if.sv
// Handshake bundle of vpack_requant: accumulator input stream and packed word output.
// The relu field exists only when VPACK_RELU_EN is defined.
interface vpack_requant_if;
  import ariane_pkg::*;

  logic                                  in_valid;
  logic                                  in_ready;
  logic signed [VPACK_ACC_W-1:0]         acc;
  logic        [VPACK_SHIFT_W-1:0]       shift;
`ifdef VPACK_RELU_EN
  logic                                  relu;
`endif
  logic                                  out_valid;
  logic                                  out_ready;
  logic [VPACK_LANES*VPACK_ELEM_W-1:0]   result;
  logic                                  sat;

  modport master (
`ifdef VPACK_RELU_EN
    output relu,
`endif
    output in_valid, acc, shift, out_ready,
    input  in_ready, out_valid, result, sat
  );

  modport slave (
`ifdef VPACK_RELU_EN
    input  relu,
`endif
    input  in_valid, acc, shift, out_ready,
    output in_ready, out_valid, result, sat
  );

endinterface

// File: rtl/vpack_round_sat.sv
// One element: rounding arithmetic right shift (half toward +inf), optional ReLU, clamp to int8.
// Optional ReLU port is present only when VPACK_RELU_EN is defined.
module vpack_round_sat
  import ariane_pkg::*;
(
  input  logic signed [VPACK_ACC_W-1:0]   acc_i,
  input  logic        [VPACK_SHIFT_W-1:0] shift_i,
`ifdef VPACK_RELU_EN
  input  logic                            relu_i,
`endif
  output logic        [VPACK_ELEM_W-1:0]  elem_o,
  output logic                            sat_o
);

  // One guard bit so acc + bias can never wrap.
  localparam int W = VPACK_ACC_W + 1;
  localparam logic signed [W-1:0] MAX_W = W'(VPACK_ELEM_MAX);
  localparam logic signed [W-1:0] MIN_W = W'(VPACK_ELEM_MIN);

  logic signed [W-1:0] ext;
  logic signed [W-1:0] bias;
  logic signed [W-1:0] r;

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can infer a latch.
    elem_o = '0;
    sat_o  = 1'b0;
    bias   = '0;
    ext    = {acc_i[VPACK_ACC_W-1], acc_i};
    if (shift_i != '0) begin
      bias = W'(1) << (shift_i - VPACK_SHIFT_W'(1));
    end
    r = (ext + bias) >>> shift_i;
`ifdef VPACK_RELU_EN
    if (relu_i && r[W-1]) begin
      r = '0;
    end
`endif
    if (r > MAX_W) begin
      elem_o = MAX_W[VPACK_ELEM_W-1:0];
      sat_o  = 1'b1;
    end else if (r < MIN_W) begin
      elem_o = MIN_W[VPACK_ELEM_W-1:0];
      sat_o  = 1'b1;
    end else begin
      elem_o = r[VPACK_ELEM_W-1:0];
    end
  end

endmodule

// File: rtl/vpack_requant.sv
// Requantize-and-pack engine: collects four requantized int8 lanes into one 32-bit word.
// Build option VPACK_RELU_EN adds a per-element ReLU clamp that does not flag saturation.
module vpack_requant
  import ariane_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  vpack_requant_if.slave   bus
);

  logic [VPACK_ELEM_W-1:0]                  lane_d;
  logic                                     lane_sat_d;
  vpack_state_e                             state_q;
  logic [1:0]                               cnt_q;
  logic [VPACK_LANES-1:0][VPACK_ELEM_W-1:0] lanes_q;
  logic                                     sat_q;

  vpack_round_sat u_round_sat (
    .acc_i   (bus.acc),
    .shift_i (bus.shift),
`ifdef VPACK_RELU_EN
    .relu_i  (bus.relu),
`endif
    .elem_o  (lane_d),
    .sat_o   (lane_sat_d)
  );

  // Handshake outputs decode only the state register: no path from out_ready to in_ready.
  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.result    = lanes_q;
  assign bus.sat       = sat_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: the lane registers are reset too, since result_o must read zero out of reset.
      state_q <= COLLECT;
      cnt_q   <= '0;
      lanes_q <= '0;
      sat_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.in_valid) begin
            lanes_q[cnt_q] <= lane_d;
            sat_q          <= sat_q | lane_sat_d;
            cnt_q          <= cnt_q + 2'd1;
            if (cnt_q == 2'(VPACK_LANES - 1)) begin
              state_q <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            lanes_q <= '0;
            sat_q   <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_vpack_requant.sv
// Self-checking bench for vpack_requant: directed cases then random words against a
// floor-division/clamp reference model computed with 64-bit integer arithmetic.
module tb_vpack_requant;
  import ariane_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vpack_requant_if bus ();

  vpack_requant dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // {sat, int8}: floor((acc + 2^(sh-1)) / 2^sh), optional relu, clamp to int8.
  function automatic logic [8:0] ref_elem(input int acc, input int sh, input bit relu);
    longint r;
    logic [7:0] b;
    logic s;
    if (sh == 0) r = longint'(acc);
    else         r = (longint'(acc) + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    s = 1'b0;
    if (r > 127)       begin r = 127;  s = 1'b1; end
    else if (r < -128) begin r = -128; s = 1'b1; end
    b = r[7:0];
    return {s, b};
  endfunction

  function automatic logic [32:0] ref_word(input int a [4], input int sh, input bit relu);
    logic [32:0] w;
    logic [8:0]  e;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      e = ref_elem(a[i], sh, relu);
      w[8*i +: 8] = e[7:0];
      w[32] = w[32] | e[8];
    end
    return w;
  endfunction

  task automatic drive(input int acc, input int sh, input bit relu);
    bus.in_valid = 1'b1;
    bus.acc      = acc;
    bus.shift    = 5'(sh);
`ifdef VPACK_RELU_EN
    bus.relu     = relu;
`endif
    @(negedge clk);
  endtask

  task automatic push_word(input string tag, input int a [4], input int sh, input bit relu);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check({tag, "_no_early_valid"}, 32'(bus.out_valid), 32'd0);
      drive(a[i], sh, relu);
    end
    bus.in_valid = 1'b0;
    // 4th accept was on the posedge just passed: out_valid must already be high.
    check({tag, "_latency"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic expect_word(input string tag, input logic [32:0] exp);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, bus.result, exp[31:0]);
    check({tag, "_sat"}, 32'(bus.sat), 32'(exp[32]));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a [4];
    int sh;
    bit relu;
    logic [32:0] exp;

    bus.in_valid  = 1'b0;
    bus.acc       = '0;
    bus.shift     = '0;
    bus.out_ready = 1'b0;
`ifdef VPACK_RELU_EN
    bus.relu      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result,         32'd0);
    check("rst_sat",       32'(bus.sat),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1..4: directed arithmetic cases
    a = '{1, -2, 3, -4};
    push_word("t1", a, 0, 1'b0);
    expect_word("t1", {1'b0, 32'hFC03FE01});
    a = '{24, -24, 23, -8};
    push_word("t2", a, 4, 1'b0);
    expect_word("t2", {1'b0, 32'h0001FF02});
    a = '{1000, -1000, 127, -128};
    push_word("t3", a, 0, 1'b0);
    expect_word("t3", {1'b1, 32'h807F807F});
    a = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    push_word("t4", a, 1, 1'b0);
    expect_word("t4", {1'b1, 32'h7F7F7F7F});

    // 5: consumer stall with input still offered
    a = '{10, 20, 30, 40};
    push_word("t5", a, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.acc      = 99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall_result",   bus.result,         32'h281E140A);
      check("t5_stall_in_ready", 32'(bus.in_ready),  32'd0);
      check("t5_stall_valid",    32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    expect_word("t5", {1'b0, 32'h281E140A});
    a = '{-1, -2, -3, -4};
    push_word("t5b", a, 0, 1'b0);
    expect_word("t5b", {1'b0, 32'hFCFDFEFF});

    // 6: flush mid-word (flush wins over a simultaneous accept)
    drive(100, 0, 1'b0);
    drive(101, 0, 1'b0);
    flush = 1'b1;
    drive(102, 0, 1'b0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_flush_ready", 32'(bus.in_ready), 32'd1);
    a = '{5, 6, 7, 8};
    push_word("t6", a, 0, 1'b0);
    expect_word("t6", {1'b0, 32'h08070605});

    // 6b: flush during OUTPUT with out_ready high drops the word
    a = '{1000, 1, 2, 3};
    push_word("t6b", a, 0, 1'b0);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.out_ready = 1'b0;
    check("t6b_dropped",  32'(bus.out_valid), 32'd0);
    check("t6b_ready",    32'(bus.in_ready),  32'd1);
    a = '{5, 6, 7, 8};
    push_word("t6c", a, 0, 1'b0);
    expect_word("t6c", {1'b0, 32'h08070605});

    // Reset while a word is pending clears everything, including result
    a = '{9, 9, 9, 9};
    push_word("t7", a, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t7_rst_result", bus.result,         32'd0);
    check("t7_rst_valid",  32'(bus.out_valid), 32'd0);
    check("t7_rst_ready",  32'(bus.in_ready),  32'd1);

    // Random words with random consumer stalls
    for (int w = 0; w < 40; w++) begin
      sh = int'($urandom_range(0, 31));
`ifdef VPACK_RELU_EN
      relu = 1'($urandom);
`else
      relu = 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 2))
          0:       a[i] = int'($urandom);
          1:       a[i] = int'($urandom_range(0, 2000)) - 1000;
          default: a[i] = int'($urandom_range(0, 64)) - 32;
        endcase
      end
      exp = ref_word(a, sh, relu);
      push_word("rnd", a, sh, relu);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        @(negedge clk);
        check("rnd_stall_result", bus.result, exp[31:0]);
      end
      expect_word("rnd", exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
